tx_cordic_polar2rect: RTL and testbench

//  Rotation-mode CORDIC for the TX path. Converts (magnitude, phase) to I/Q (x_out, y_out).

---
 rtl/tx_cordic_polar2rect_pkg.sv | 28 ++
 rtl/tx_cordic_polar2rect_if.sv | 24 ++
 rtl/tx_cordic_polar2rect_stage.sv | 52 +++++
 rtl/tx_cordic_polar2rect.sv | 139 +++++++++++++
 tb/tb_tx_cordic_polar2rect.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/tx_cordic_polar2rect_pkg.sv
// tx_cordic_pkg: constants and helpers shared by the TX rotation CORDIC.
// Angles are signed radians*2^13; gain constant is Q15.
package tx_cordic_pkg;

   localparam int NUM_ITER      = 13;
   localparam int ANGLE_HALF_PI = 12868;
   localparam int ANGLE_PI      = 25736;
   localparam int CORDIC_K_Q15  = 19899;

   localparam int ATAN_TABLE [0:NUM_ITER-1] = '{
      6434, 3798, 2007, 1019, 511, 256, 128,
      64, 32, 16, 8, 4, 2
   };

   // Clamp v to the signed range of a w-bit word.
   function automatic int saturate(input int v, input int w);
      int hi;
      int lo;
      int r;
      hi = (1 << (w - 1)) - 1;
      lo = -hi - 1;
      r  = v;
      if (v > hi) r = hi;
      if (v < lo) r = lo;
      return r;
   endfunction

endpackage

// File: rtl/tx_cordic_polar2rect_if.sv
// tx_cordic_polar2rect_if: sample bus of the TX rotation CORDIC.
// master drives nd/mag_in/phase_in, slave returns rdy/x_out/y_out.
interface tx_cordic_polar2rect_if #(
   parameter int DATA_WIDTH = 16
);

   logic                         nd;
   logic signed [DATA_WIDTH-1:0] mag_in;
   logic signed [DATA_WIDTH-1:0] phase_in;
   logic                         rdy;
   logic signed [DATA_WIDTH-1:0] x_out;
   logic signed [DATA_WIDTH-1:0] y_out;

   modport master (
      output nd, mag_in, phase_in,
      input  rdy, x_out, y_out
   );

   modport slave (
      input  nd, mag_in, phase_in,
      output rdy, x_out, y_out
   );

endinterface

// File: rtl/tx_cordic_polar2rect_stage.sv
// tx_cordic_stage: one registered CORDIC micro-rotation by +/-atan(2^-SHIFT).
// Ports: clk, sclr_n (async low), i_x/i_y/i_z in, o_x/o_y/o_z registered out.
module tx_cordic_stage #(
   parameter int XW    = 18,
   parameter int ZW    = 16,
   parameter int SHIFT = 0,
   parameter int ATAN  = 0
)(
   input  logic                 clk,
   input  logic                 sclr_n,
   input  logic signed [XW-1:0] i_x,
   input  logic signed [XW-1:0] i_y,
   input  logic signed [ZW-1:0] i_z,
   output logic signed [XW-1:0] o_x,
   output logic signed [XW-1:0] o_y,
   output logic signed [ZW-1:0] o_z
);

   localparam logic signed [ZW-1:0] L_ATAN = ZW'(ATAN);

   logic                 w_pos;
   logic signed [XW-1:0] w_xs;
   logic signed [XW-1:0] w_ys;
   logic signed [XW-1:0] r_x;
   logic signed [XW-1:0] r_y;
   logic signed [ZW-1:0] r_z;

   assign w_pos = ~i_z[ZW-1];
   assign w_xs  = i_x >>> SHIFT;
   assign w_ys  = i_y >>> SHIFT;

   always_ff @(posedge clk or negedge sclr_n) begin
      if (!sclr_n) begin
         r_x <= '0;
         r_y <= '0;
         r_z <= '0;
      end else if (w_pos) begin
         r_x <= i_x - w_ys;
         r_y <= i_y + w_xs;
         r_z <= i_z - L_ATAN;
      end else begin
         r_x <= i_x + w_ys;
         r_y <= i_y - w_xs;
         r_z <= i_z + L_ATAN;
      end
   end

   assign o_x = r_x;
   assign o_y = r_y;
   assign o_z = r_z;

endmodule

// File: rtl/tx_cordic_polar2rect.sv
// tx_cordic_polar2rect: pipelined rotation CORDIC, (mag, phase) -> (x, y).
// Ports: clk, sclr_n (async low), s_if slave: nd/mag_in/phase_in in,
// rdy/x_out/y_out out. rdy is nd delayed by LAT (15, or 16 with gain).
// Macro CORDIC_GAIN_COMP_EN adds a Q15 1/K gain stage before the output.
module tx_cordic_polar2rect
   import tx_cordic_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int GUARD_BITS = 2
)(
   input  logic              clk,
   input  logic              sclr_n,
   tx_cordic_polar2rect_if.slave s_if
);

   localparam int DW = DATA_WIDTH;
   localparam int XW = DATA_WIDTH + GUARD_BITS;
`ifdef CORDIC_GAIN_COMP_EN
   localparam int LAT = NUM_ITER + 3;
`else
   localparam int LAT = NUM_ITER + 2;
`endif
   localparam logic signed [DW-1:0] L_HP = DW'(ANGLE_HALF_PI);

   logic signed [XW-1:0] w_mag;
   logic signed [DW-1:0] w_ph;
   logic signed [XW-1:0] r_x0;
   logic signed [XW-1:0] r_y0;
   logic signed [DW-1:0] r_z0;
   logic signed [XW-1:0] w_x [0:NUM_ITER];
   logic signed [XW-1:0] w_y [0:NUM_ITER];
   logic signed [DW-1:0] w_z [0:NUM_ITER];
   logic signed [DW-1:0] w_unused_z;
   logic signed [XW-1:0] w_fx;
   logic signed [XW-1:0] w_fy;
   logic signed [DW-1:0] r_xo;
   logic signed [DW-1:0] r_yo;
   logic [LAT-1:0]       r_vld;

   assign w_mag = XW'(s_if.mag_in);
   assign w_ph  = s_if.phase_in;

   // Fold the angle into [-pi/2, pi/2] so the micro-rotations converge.
   always_ff @(posedge clk or negedge sclr_n) begin
      if (!sclr_n) begin
         r_x0 <= '0;
         r_y0 <= '0;
         r_z0 <= '0;
      end else if (w_ph > L_HP) begin
         r_x0 <= '0;
         r_y0 <= w_mag;
         r_z0 <= w_ph - L_HP;
      end else if (w_ph < -L_HP) begin
         r_x0 <= '0;
         r_y0 <= -w_mag;
         r_z0 <= w_ph + L_HP;
      end else begin
         r_x0 <= w_mag;
         r_y0 <= '0;
         r_z0 <= w_ph;
      end
   end

   assign w_x[0] = r_x0;
   assign w_y[0] = r_y0;
   assign w_z[0] = r_z0;

   for (genvar g = 0; g < NUM_ITER; g++) begin : g_rot
      tx_cordic_stage #(
         .XW    (XW),
         .ZW    (DW),
         .SHIFT (g),
         .ATAN  (ATAN_TABLE[g])
      ) u_stage (
         .clk    (clk),
         .sclr_n (sclr_n),
         .i_x    (w_x[g]),
         .i_y    (w_y[g]),
         .i_z    (w_z[g]),
         .o_x    (w_x[g+1]),
         .o_y    (w_y[g+1]),
         .o_z    (w_z[g+1])
      );
   end

   // Residual angle after the last rotation is not needed.
   assign w_unused_z = w_z[NUM_ITER];

`ifdef CORDIC_GAIN_COMP_EN
   localparam int PW = XW + 16;
   localparam logic signed [PW-1:0] L_K   = PW'(CORDIC_K_Q15);
   localparam logic signed [PW-1:0] L_RND = PW'(1 << 14);

   logic signed [PW-1:0] w_px;
   logic signed [PW-1:0] w_py;
   logic signed [XW-1:0] r_gx;
   logic signed [XW-1:0] r_gy;

   // Q15 scale with round-half-up; result never exceeds the input range.
   assign w_px = PW'(w_x[NUM_ITER]) * L_K + L_RND;
   assign w_py = PW'(w_y[NUM_ITER]) * L_K + L_RND;

   always_ff @(posedge clk or negedge sclr_n) begin
      if (!sclr_n) begin
         r_gx <= '0;
         r_gy <= '0;
      end else begin
         r_gx <= XW'(w_px >>> 15);
         r_gy <= XW'(w_py >>> 15);
      end
   end

   assign w_fx = r_gx;
   assign w_fy = r_gy;
`else
   assign w_fx = w_x[NUM_ITER];
   assign w_fy = w_y[NUM_ITER];
`endif

   always_ff @(posedge clk or negedge sclr_n) begin
      if (!sclr_n) begin
         r_xo <= '0;
         r_yo <= '0;
      end else begin
         r_xo <= DW'(saturate(int'(w_fx), DW));
         r_yo <= DW'(saturate(int'(w_fy), DW));
      end
   end

   always_ff @(posedge clk or negedge sclr_n) begin
      if (!sclr_n) r_vld <= '0;
      else         r_vld <= {r_vld[LAT-2:0], s_if.nd};
   end

   assign s_if.rdy   = r_vld[LAT-1];
   assign s_if.x_out = r_xo;
   assign s_if.y_out = r_yo;

endmodule

// File: tb/tb_tx_cordic_polar2rect.sv
// tb_tx_cordic_polar2rect: table vectors, random streams against a
// trig reference model, and reset/latency sequences.
module tb_tx_cordic_polar2rect;
   import tx_cordic_pkg::*;

   localparam int DW = 16;
`ifdef CORDIC_GAIN_COMP_EN
   localparam int  LAT  = 16;
   localparam real GAIN = 1.6467602581 * 19899.0 / 32768.0;
`else
   localparam int  LAT  = 15;
   localparam real GAIN = 1.6467602581;
`endif

   typedef struct {
      int mag;
      int ph;
      int ex;
      int ey;
      int tx;
      int ty;
   } vec_t;

   logic clk = 1'b0;
   logic sclr_n;
   int   n_pass = 0;
   int   n_tot  = 0;
   vec_t tbl [$];
   bit   q_nd  [$];
   bit   q_chk [$];
   int   q_mag [$];
   int   q_ph  [$];

   always #5 clk = ~clk;

   tx_cordic_polar2rect_if #(.DATA_WIDTH(DW)) bus ();

   tx_cordic_polar2rect #(
      .DATA_WIDTH (DW),
      .GUARD_BITS (2)
   ) dut (
      .clk    (clk),
      .sclr_n (sclr_n),
      .s_if   (bus)
   );

   task automatic check(input string nm, input int act,
                        input int exp, input int tol);
      int d;
      d = act - exp;
      if (d < 0) d = -d;
      n_tot++;
      if (d <= tol) n_pass++;
      else $display("FAIL %s: got %0d, want %0d (tol %0d)",
                    nm, act, exp, tol);
   endtask

   function automatic int rnd_sat(input real v);
      if (v >= 32767.0) return 32767;
      if (v <= -32768.0) return -32768;
      return $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
   endfunction

   function automatic int ref_x(input int mag, input int ph);
      return rnd_sat(real'(mag) * GAIN * $cos(real'(ph) / 8192.0));
   endfunction

   function automatic int ref_y(input int mag, input int ph);
      return rnd_sat(real'(mag) * GAIN * $sin(real'(ph) / 8192.0));
   endfunction

   function automatic int ref_tol(input int mag);
      int a;
      a = (mag < 0) ? -mag : mag;
      return 8 + $rtoi(real'(a) * GAIN / 1024.0);
   endfunction

   task automatic drive(input bit nd, input int mag, input int ph);
      bus.nd       = nd;
      bus.mag_in   = 16'(mag);
      bus.phase_in = 16'(ph);
   endtask

   function automatic int rnd_mag(input int lim);
      return int'($urandom_range(0, 2 * lim)) - lim;
   endfunction

   function automatic int rnd_ph();
      return int'($urandom_range(0, 2 * ANGLE_PI)) - ANGLE_PI;
   endfunction

   task automatic push(input bit nd, input bit chk,
                       input int mag, input int ph);
      q_nd.push_back(nd);
      q_chk.push_back(chk);
      q_mag.push_back(mag);
      q_ph.push_back(ph);
   endtask

   task automatic clear_q();
      q_nd.delete();
      q_chk.delete();
      q_mag.delete();
      q_ph.delete();
   endtask

   // Starts and ends #1 after a rising edge with an empty pipeline.
   task automatic run_stream(input string nm);
      int n;
      int k;
      bit e;
      n = q_nd.size();
      for (int c = 0; c < n + LAT; c++) begin
         if (c < n) drive(q_nd[c], q_mag[c], q_ph[c]);
         else       drive(1'b0, 0, 0);
         @(posedge clk);
         #1;
         k = c - LAT + 1;
         e = (k >= 0 && k < n) ? q_nd[k] : 1'b0;
         check({nm, "_rdy"}, int'(bus.rdy), int'(e), 0);
         if (e && bus.rdy && q_chk[k]) begin
            check({nm, "_x"}, int'(bus.x_out),
                  ref_x(q_mag[k], q_ph[k]), ref_tol(q_mag[k]));
            check({nm, "_y"}, int'(bus.y_out),
                  ref_y(q_mag[k], q_ph[k]), ref_tol(q_mag[k]));
         end
      end
   endtask

   initial begin
`ifdef CORDIC_GAIN_COMP_EN
      tbl.push_back(vec_t'{16384,      0,  16384,      0, 4, 4});
      tbl.push_back(vec_t'{16384,  12868,      0,  16384, 4, 4});
      tbl.push_back(vec_t'{16384, -12868,      0, -16384, 4, 4});
      tbl.push_back(vec_t'{16384,  25736, -16384,      0, 4, 4});
      tbl.push_back(vec_t'{16384,  -6434,  11585, -11585, 4, 4});
      tbl.push_back(vec_t'{    0,   1000,      0,      0, 0, 0});
`else
      tbl.push_back(vec_t'{ 16384,      0,  26981,      0,  6,  6});
      tbl.push_back(vec_t'{ 16384,  12868,      0,  26981, 12, 12});
      tbl.push_back(vec_t'{ 16384, -12868,      0, -26981, 12, 12});
      tbl.push_back(vec_t'{ 16384,  25736, -26981,      0, 12, 12});
      tbl.push_back(vec_t'{ 16384,  -6434,  19078, -19078, 12, 12});
      tbl.push_back(vec_t'{-16384,      0, -26981,      0,  8,  8});
      tbl.push_back(vec_t'{ 32767,      0,  32767,      0,  0, 24});
      tbl.push_back(vec_t'{ 32767,  25736, -32768,      0,  0, 24});
      tbl.push_back(vec_t'{-32768,      0, -32768,      0,  0, 24});
      tbl.push_back(vec_t'{     0,   5000,      0,      0,  0,  0});
`endif

      sclr_n = 1'b0;
      drive(1'b0, 0, 0);
      #12;
      check("reset_rdy", int'(bus.rdy), 0, 0);
      check("reset_x", int'(bus.x_out), 0, 0);
      check("reset_y", int'(bus.y_out), 0, 0);
      @(posedge clk);
      #1;
      sclr_n = 1'b1;

      foreach (tbl[i]) begin
         drive(1'b1, tbl[i].mag, tbl[i].ph);
         @(posedge clk);
         #1;
         drive(1'b0, 0, 0);
         repeat (LAT - 2) @(posedge clk);
         #1;
         check($sformatf("tbl%0d_early", i), int'(bus.rdy), 0, 0);
         @(posedge clk);
         #1;
         check($sformatf("tbl%0d_rdy", i), int'(bus.rdy), 1, 0);
         check($sformatf("tbl%0d_x", i), int'(bus.x_out),
               tbl[i].ex, tbl[i].tx);
         check($sformatf("tbl%0d_y", i), int'(bus.y_out),
               tbl[i].ey, tbl[i].ty);
      end

      clear_q();
      for (int i = 0; i < 64; i++) push(1'b1, 1'b1, rnd_mag(16000), rnd_ph());
      for (int i = 0; i < 3; i++)  push(1'b0, 1'b0, rnd_mag(16000), rnd_ph());
      for (int i = 0; i < 10; i++) push(1'b1, 1'b1, rnd_mag(16000), rnd_ph());
      run_stream("stream");

      clear_q();
      for (int i = 0; i < 40; i++) begin
         if (i % 9 == 4) push(1'b1, 1'b0, rnd_mag(32767), 30000);
         else push(1'($urandom_range(0, 1)), 1'b1, rnd_mag(32767), rnd_ph());
      end
      run_stream("gaps");

      for (int c = 0; c < LAT + 7; c++) begin
         drive(1'b1, 20000, rnd_ph());
         @(posedge clk);
         #1;
      end
      check("midrst_before_rdy", int'(bus.rdy), 1, 0);
      #2;
      sclr_n = 1'b0;
      drive(1'b0, 0, 0);
      #1;
      check("midrst_rdy", int'(bus.rdy), 0, 0);
      check("midrst_x", int'(bus.x_out), 0, 0);
      check("midrst_y", int'(bus.y_out), 0, 0);
      @(posedge clk);
      @(posedge clk);
      #3;
      sclr_n = 1'b1;
      @(posedge clk);
      #1;

      clear_q();
      for (int i = 0; i < 20; i++) push(1'b0, 1'b0, 0, 0);
      push(1'b1, 1'b1, 12000, 3000);
      for (int i = 0; i < 4; i++) push(1'b0, 1'b0, 0, 0);
      run_stream("postrst");

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
